bitop_unit: RTL and testbench

BITOP_UNIT -- requirements
Module: bitop_unit

---
 rtl/bitop_unit.sv | 155 +++++++++++++++
 tb/tb_bitop_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitop_unit.sv
// rtl/bitop_unit.sv - single-bit manipulation and population-count unit
//
// Purpose: accepts one request at a time (SET/CLR/TGL/TEST on a bit index,
// or POPCNT of a word) and returns a registered result and status through a
// valid/ready handshake. Single-bit ops complete in one cycle; POPCNT walks
// the word one bit per cycle for NUM cycles.
//
// Ports:
//   i_clk     clock, all state on rising edge
//   i_rst     synchronous active-high reset
//   i_valid   request valid            o_ready  unit idle, can accept
//   i_op      opcode (0 SET, 1 CLR, 2 TGL, 3 TEST, 4 POPCNT, 5..7 illegal)
//   i_argA    operand word             i_argB   bit index (unused by POPCNT)
//   o_valid   result valid             i_ready  consumer accepts result
//   o_result  registered result        o_status 00 OK, 01 range, 10 illegal

module bitop_unit #(
  parameter int NUM   = 8,
  parameter int CNT_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [2:0]     i_op,
  input  logic [NUM-1:0] i_argA,
  input  logic [NUM-1:0] i_argB,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [NUM-1:0] o_result,
  output logic [1:0]     o_status
);

  if (NUM < 2 || NUM > 32) begin : g_bad_num
    $error("bitop_unit: NUM must be in 2..32");
  end
  if (CNT_W != $clog2(NUM + 1)) begin : g_bad_cnt_w
    $error("bitop_unit: CNT_W must equal $clog2(NUM+1)");
  end

  localparam logic [2:0] OP_SET    = 3'd0;
  localparam logic [2:0] OP_CLR    = 3'd1;
  localparam logic [2:0] OP_TGL    = 3'd2;
  localparam logic [2:0] OP_POPCNT = 3'd4;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_RANGE = 2'b01;
  localparam logic [1:0] ST_ILL   = 2'b10;

  // NUM always fits in NUM bits for NUM >= 2, so the range check compares
  // the full index word without truncation.
  localparam logic [NUM-1:0]   NUM_V    = NUM'(NUM);
  localparam logic [NUM-1:0]   ONE_V    = NUM'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NUM-1:0]   result_q, result_d;
  logic [1:0]       status_q, status_d;
  logic [NUM-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM-1:0]   mask;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mask     = ONE_V << i_argB;

    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          // Illegal opcode is decided before the index range check.
          if (i_op > OP_POPCNT) begin
            state_d  = S_DONE;
            result_d = '0;
            status_d = ST_ILL;
          end else if (i_op == OP_POPCNT) begin
            state_d = S_BUSY;
            shreg_d = i_argA;
            acc_d   = '0;
            cnt_d   = '0;
          end else if (i_argB >= NUM_V) begin
            state_d  = S_DONE;
            result_d = '0;
            status_d = ST_RANGE;
          end else begin
            state_d  = S_DONE;
            status_d = ST_OK;
            case (i_op)
              OP_SET:  result_d = i_argA | mask;
              OP_CLR:  result_d = i_argA & ~mask;
              OP_TGL:  result_d = i_argA ^ mask;
              default: result_d = {{(NUM-1){1'b0}}, |(i_argA & mask)};
            endcase
          end
        end
      end

      S_BUSY: begin
        acc_d   = acc_q + CNT_W'(shreg_q[0]);
        shreg_d = shreg_q >> 1;
        if (cnt_q == LAST_CNT) begin
          // Last bit folded in this cycle: publish the final count.
          state_d  = S_DONE;
          result_d = NUM'(acc_d);
          status_d = ST_OK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      status_q <= ST_OK;
      shreg_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_status = status_q;

endmodule

// File: tb/tb_bitop_unit.sv
// tb/tb_bitop_unit.sv - self-checking bench for bitop_unit (NUM=8)

module tb_bitop_unit;

  localparam int NUM = 8;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic [2:0]     i_op;
  logic [NUM-1:0] i_argA;
  logic [NUM-1:0] i_argB;
  logic           o_valid;
  logic           i_ready;
  logic [NUM-1:0] o_result;
  logic [1:0]     o_status;

  bitop_unit #(.NUM(NUM), .CNT_W(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_argA  (i_argA),
    .i_argB  (i_argB),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_status(o_status)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int last_res = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [1:0] st;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: bit values derived arithmetically from the word.
  task automatic model(input int op, input int a, input int b,
                       output int r, output int s, output int lat);
    int bitval, weight, v, n;
    lat = 1;
    r   = 0;
    s   = 0;
    if (op >= 5) begin
      s = 2;
    end else if (op == 4) begin
      n = 0;
      v = a;
      while (v != 0) begin
        n += v % 2;
        v /= 2;
      end
      r   = n;
      lat = NUM + 1;
    end else if (b >= NUM) begin
      s = 1;
    end else begin
      weight = 2 ** b;
      bitval = (a / weight) % 2;
      case (op)
        0: r = bitval ? a : a + weight;
        1: r = bitval ? a - weight : a;
        2: r = bitval ? a - weight : a + weight;
        default: r = bitval;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue one request, wait for its result, hold i_ready low for 'hold'
  // cycles, then complete the handshake. All expectations come from caller.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input int hold,
                        input int exp_res, input int exp_st, input int exp_lat);
    int guard;
    int lat;
    guard = 0;
    while (!o_ready && guard < 50) begin
      tick();
      guard++;
    end
    i_op    = op;
    i_argA  = a;
    i_argB  = b;
    i_valid = 1'b1;
    i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    i_op    = 3'($urandom);
    i_argA  = 8'($urandom);
    i_argB  = 8'($urandom);
    lat = 1;
    while (!o_valid && lat < 40) begin
      check({tag, " busy_hold"}, o_result, last_res);
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, o_result, exp_res);
    check({tag, " status"}, o_status, exp_st);
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, " stall_valid"}, o_valid, 1);
      check({tag, " stall_result"}, o_result, exp_res);
      check({tag, " stall_ready"}, o_ready, 0);
    end
    i_ready = 1'b1;
    tick();
    i_ready  = 1'b0;
    last_res = exp_res;
    check({tag, " idle_ready"}, o_ready, 1);
    check({tag, " idle_valid"}, o_valid, 0);
  endtask

  initial begin
    int r, s, l, seen;
    logic [2:0] op;
    logic [7:0] a, b;

    vecs[0]  = '{3'd0, 8'h00, 8'd3,   8'h08, 2'b00, 1};
    vecs[1]  = '{3'd2, 8'hFF, 8'd7,   8'h7F, 2'b00, 1};
    vecs[2]  = '{3'd1, 8'h0F, 8'd9,   8'h00, 2'b01, 1};
    vecs[3]  = '{3'd4, 8'hB5, 8'd0,   8'h05, 2'b00, 9};
    vecs[4]  = '{3'd4, 8'hFF, 8'd3,   8'h08, 2'b00, 9};
    vecs[5]  = '{3'd6, 8'hFF, 8'd20,  8'h00, 2'b10, 1};
    vecs[6]  = '{3'd3, 8'h04, 8'd2,   8'h01, 2'b00, 1};
    vecs[7]  = '{3'd0, 8'h00, 8'd8,   8'h00, 2'b01, 1};
    vecs[8]  = '{3'd3, 8'h80, 8'd7,   8'h01, 2'b00, 1};
    vecs[9]  = '{3'd1, 8'hFF, 8'd0,   8'hFE, 2'b00, 1};
    vecs[10] = '{3'd4, 8'h00, 8'd200, 8'h00, 2'b00, 9};
    vecs[11] = '{3'd7, 8'hAA, 8'd1,   8'h00, 2'b10, 1};
    vecs[12] = '{3'd2, 8'h00, 8'd0,   8'h01, 2'b00, 1};
    vecs[13] = '{3'd0, 8'h01, 8'd255, 8'h00, 2'b01, 1};

    // Reset with i_valid high: the request must not be taken.
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_op    = 3'd0;
    i_argA  = 8'h00;
    i_argB  = 8'd1;
    i_ready = 1'b0;
    tick();
    tick();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    check("reset ready", o_ready, 1);
    check("reset valid", o_valid, 0);
    check("reset result", o_result, 0);
    check("reset status", o_status, 0);
    tick();
    check("reset no_accept", o_valid, 0);

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
             vecs[i].res, vecs[i].st, vecs[i].lat);
    end

    // Result held under backpressure.
    run_op("stall", 3'd3, 8'h04, 8'd2, 5, 8'h01, 0, 1);

    // Reset during the 4th BUSY cycle of a POPCNT.
    run_op("pre_rst", 3'd0, 8'h10, 8'd1, 0, 8'h12, 0, 1);
    i_op    = 3'd4;
    i_argA  = 8'hFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("rst_busy result_hold", o_result, last_res);
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_busy ready", o_ready, 1);
    check("rst_busy valid", o_valid, 0);
    check("rst_busy result", o_result, 0);
    check("rst_busy status", o_status, 0);
    last_res = 0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (o_valid) seen = 1;
      tick();
    end
    check("rst_busy no_result", seen, 0);
    run_op("post_rst", 3'd0, 8'h00, 8'd5, 0, 8'h20, 0, 1);

    // Randomized ops against the model.
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      model(int'(op), int'(a), int'(b), r, s, l);
      run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2), r, s, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
